// File: rtl/fan_pkg.sv
// Shared encodings for the fan off-timer: controller states
// and timer selection codes.
package fan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    EXPIRE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_OFF = 2'd0;
  localparam logic [1:0] SEL_1   = 2'd1;
  localparam logic [1:0] SEL_2   = 2'd2;
  localparam logic [1:0] SEL_3   = 2'd3;

endpackage

// File: rtl/fan_timer_mmss_down.sv
// Loadable BCD m:ss down-counter; loading zero clears it.
// Stops at 0:00 and never wraps.
module fan_timer_mmss_down
  import fan_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic       dec,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       zero
);

  assign zero = (min1 == 4'd0) && (sec10 == 4'd0)
             && (sec1 == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min1  <= 4'd0;
      sec10 <= 4'd0;
      sec1  <= 4'd0;
    end else if (load) begin
      min1  <= load_min;
      sec10 <= 4'd0;
      sec1  <= 4'd0;
    end else if (dec && !zero) begin
      if (sec1 != 4'd0) begin
        sec1 <= sec1 - 4'd1;
      end else if (sec10 != 4'd0) begin
        sec1  <= 4'd9;
        sec10 <= sec10 - 4'd1;
      end else begin
        sec1  <= 4'd9;
        sec10 <= 4'd5;
        min1  <= min1 - 4'd1;
      end
    end
  end

endmodule

// File: rtl/fan_timer_ctrl.sv
// Fan off-timer: button cycles OFF/T1/T2/T3, counts down
// mm:ss on the 1 Hz strobe, and pulses fan_stop on expiry.
module fan_timer_ctrl
  import fan_pkg::*;
#(
  parameter logic [3:0] SET1_MIN = 4'd1,
  parameter logic [3:0] SET2_MIN = 4'd3,
  parameter logic [3:0] SET3_MIN = 4'd5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_sec,
  input  logic       btn_timer,
  input  logic       fan_on,
  output logic [1:0] timer_sel,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       timer_running,
  output logic       fan_stop
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] sel_nx;
  logic [1:0] sel_inc;
  logic [3:0] set_min;
  logic       cnt_load;
  logic [3:0] cnt_min;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       last_sec;

  assign sel_inc  = timer_sel + 2'd1;
  assign last_sec = (min1 == 4'd0) && (sec10 == 4'd0)
                 && (sec1 == 4'd1);

  always_comb begin
    set_min = 4'd0;
    unique case (timer_sel)
      SEL_1:   set_min = SET1_MIN;
      SEL_2:   set_min = SET2_MIN;
      SEL_3:   set_min = SET3_MIN;
      default: set_min = 4'd0;
    endcase
  end

  // A load with cnt_min=0 doubles as the digit clear.
  always_comb begin
    state_nx = state;
    sel_nx   = timer_sel;
    cnt_load = 1'b0;
    cnt_min  = 4'd0;
    cnt_dec  = 1'b0;
    if (!fan_on) begin
      state_nx = IDLE;
      sel_nx   = SEL_OFF;
      cnt_load = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_timer) begin
            sel_nx   = SEL_1;
            state_nx = LOAD;
          end
        end
        LOAD, RUN: begin
          if (btn_timer) begin
            sel_nx = sel_inc;
            if (sel_inc == SEL_OFF) begin
              state_nx = IDLE;
              cnt_load = 1'b1;
            end else begin
              state_nx = LOAD;
            end
          end else if (state == LOAD) begin
            cnt_load = 1'b1;
            cnt_min  = set_min;
            state_nx = RUN;
          end else if (cnt_zero) begin
            state_nx = EXPIRE;
          end else if (clk_sec) begin
            cnt_dec = 1'b1;
            if (last_sec) state_nx = EXPIRE;
          end
        end
        EXPIRE: begin
          state_nx = IDLE;
          sel_nx   = SEL_OFF;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer_sel     <= SEL_OFF;
      timer_running <= 1'b0;
      fan_stop      <= 1'b0;
    end else begin
      state         <= state_nx;
      timer_sel     <= sel_nx;
      timer_running <= (state_nx == RUN);
      fan_stop      <= (state_nx == EXPIRE);
    end
  end

  fan_timer_mmss_down u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_min (cnt_min),
    .dec      (cnt_dec),
    .min1     (min1),
    .sec10    (sec10),
    .sec1     (sec1),
    .zero     (cnt_zero)
  );

endmodule
